// File: rtl/div_pkg.sv
// Shared declarations for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/adder.sv
// Add/subtract primitive: sum_o = a_i - b_i when sel_i, else a_i + b_i.
module adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = sel_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: one non-restoring add/subtract step per cycle on
// operand magnitudes, followed by a restore/sign-fix cycle.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int CW = $clog2(N);

  div_state_e    state_q, state_d;
  logic [N:0]    p_q, p_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    shift_p;
  logic [N:0]    add_a;
  logic [N:0]    add_sum;
  logic [N-1:0]  rem_mag;

  // {P,Q} shifted left; the dropped P MSB is redundant since |2P| < 2|D|.
  assign shift_p = {p_q[N-1:0], q_q[N-1]};
  assign add_a   = (state_q == CALC) ? shift_p : p_q;

  adder #(.W(N + 1)) u_adder (
    .a_i   (add_a),
    .b_i   ({1'b0, d_q}),
    .sel_i (~p_q[N]),
    .sum_o (add_sum)
  );

  assign rem_mag = p_q[N] ? add_sum[N-1:0] : p_q[N-1:0];

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          q_d       = dividend_i[N-1] ? -dividend_i : dividend_i;
          d_d       = divisor_i[N-1]  ? -divisor_i  : divisor_i;
          p_d       = '0;
          cnt_d     = CW'(N - 1);
          neg_quo_d = dividend_i[N-1] ^ divisor_i[N-1];
          neg_rem_d = dividend_i[N-1];
          busy_d    = 1'b1;
          if (divisor_i == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = add_sum;
        q_d   = {q_q[N-2:0], ~add_sum[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quo_d   = neg_quo_q ? -q_q : q_q;
        rem_d   = neg_rem_q ? -rem_mag : rem_mag;
        dbz_d   = 1'b0;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign valid_o       = valid_q;
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
